// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter sharing one word-wide data memory between the data cache (port 0)
// and the instruction refill path (port 1). Define MEM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c0_read,
  input  logic              c0_write,
  input  logic [ADDR_W-1:0] c0_address,
  input  logic [DATA_W-1:0] c0_writedata,
  output logic [DATA_W-1:0] c0_readdata,
  output logic              c0_busywait,
  input  logic              c1_read,
  input  logic              c1_write,
  input  logic [ADDR_W-1:0] c1_address,
  input  logic [DATA_W-1:0] c1_writedata,
  output logic [DATA_W-1:0] c1_readdata,
  output logic              c1_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   first_q, first_d;
  logic   grant_q, grant_d;
  logic   wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic   last_q, last_d;
`endif

  logic [1:0] req;
  logic [1:0] wr_in;
  logic [1:0] busy;
  logic [1:0][ADDR_W-1:0] addr_in;
  logic [1:0][DATA_W-1:0] wdata_in;
  logic       win;

  assign req      = {c1_read | c1_write, c0_read | c0_write};
  assign wr_in    = {c1_write, c0_write};
  assign addr_in  = {c1_address, c0_address};
  assign wdata_in = {c1_writedata, c0_writedata};

  // A port is released only during its own RELEASE cycle; everyone else keeps stalling.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_busy
      assign busy[gi] = req[gi] & ~((state_q == S_RELEASE) && (grant_q == 1'(gi)));
    end
  endgenerate

  assign c0_busywait = busy[0];
  assign c1_busywait = busy[1];
  assign c0_readdata = rdata_q[0];
  assign c1_readdata = rdata_q[1];

  assign mem_read      = (state_q == S_ACCESS) & ~wr_q;
  assign mem_write     = (state_q == S_ACCESS) &  wr_q;
  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;

  always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    win = ~req[0];
`else
    if (req[0] && req[1]) win = ~last_q;
    else                  win = ~req[0];
`endif
  end

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_ACCESS;
          first_d = 1'b1;
          grant_d = win;
          wr_d    = wr_in[win];
          addr_d  = addr_in[win];
          wdata_d = wdata_in[win];
`ifndef MEM_ARB_FIXED_PRIO_EN
          last_d  = win;
`endif
        end
      end
      S_ACCESS: begin
        // The first ACCESS cycle is unconditional so memory has seen the strobe before we sample busy.
        if (first_q) begin
          first_d = 1'b0;
        end else if (!mem_busywait) begin
          state_d = S_RELEASE;
          if (!wr_q) rdata_d[grant_q] = mem_readdata;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      first_q <= 1'b0;
      grant_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_port_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        c0_read = 0, c0_write = 0, c1_read = 0, c1_write = 0;
  logic [5:0]  c0_address = 0, c1_address = 0;
  logic [31:0] c0_writedata = 0, c1_writedata = 0;
  logic [31:0] c0_readdata, c1_readdata;
  logic        c0_busywait, c1_busywait;
  logic        mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .c0_read(c0_read), .c0_write(c0_write), .c0_address(c0_address),
    .c0_writedata(c0_writedata), .c0_readdata(c0_readdata), .c0_busywait(c0_busywait),
    .c1_read(c1_read), .c1_write(c1_write), .c1_address(c1_address),
    .c1_writedata(c1_writedata), .c1_readdata(c1_readdata), .c1_busywait(c1_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  // Memory: busy for mem_lat cycles after the strobe is first seen; data is a function of address.
  int mem_lat = 1;
  int mem_cnt = 0;
  always @(posedge clock) mem_cnt <= (mem_read | mem_write) ? mem_cnt + 1 : 0;
  assign mem_busywait = (mem_read | mem_write) && (mem_cnt < mem_lat);

  function automatic logic [31:0] mem_word(input logic [5:0] a);
    if (a == 6'h05) return 32'hDEADBEEF;
    return 32'hA5000000 | {26'd0, a};
  endfunction
  assign mem_readdata = mem_word(mem_address);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Reference model: one transaction at a time, tracked by owner, edges elapsed and release flag.
  int          m_port, m_age, m_last;
  bit          m_rel, m_wr;
  logic [5:0]  m_addr;
  logic [31:0] m_wdata, m_rd0, m_rd1;

  always @(posedge clock or negedge reset) begin
    bit q0, q1;
    int w;
    q0 = c0_read | c0_write;
    q1 = c1_read | c1_write;
    if (!reset) begin
      m_port = -1; m_age = 0; m_last = 1; m_rel = 0; m_wr = 0;
      m_addr = 0; m_wdata = 0; m_rd0 = 0; m_rd1 = 0;
    end else if (m_rel) begin
      m_rel = 0;
      m_port = -1;
    end else if (m_port >= 0) begin
      if (m_age >= 1 && !mem_busywait) begin
        if (!m_wr) begin
          if (m_port == 0) m_rd0 = mem_readdata;
          else             m_rd1 = mem_readdata;
        end
        m_rel = 1;
      end
      m_age++;
    end else if (q0 || q1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      w = q0 ? 0 : 1;
`else
      if (q0 && q1) w = (m_last == 0) ? 1 : 0;
      else          w = q0 ? 0 : 1;
`endif
      m_port = w;
      m_age  = 0;
      m_last = w;
      m_wr   = (w == 0) ? c0_write : c1_write;
      m_addr = (w == 0) ? c0_address : c1_address;
      m_wdata = (w == 0) ? c0_writedata : c1_writedata;
    end
  end

  always @(negedge clock) begin
    bit act;
    if (reset === 1'b1 && chk_en) begin
      act = (m_port >= 0) && !m_rel;
      check("mem_read", 32'(mem_read), 32'(act && !m_wr));
      check("mem_write", 32'(mem_write), 32'(act && m_wr));
      if (act) check("mem_address", 32'(mem_address), 32'(m_addr));
      if (act && m_wr) check("mem_writedata", mem_writedata, m_wdata);
      check("c0_readdata", c0_readdata, m_rd0);
      check("c1_readdata", c1_readdata, m_rd1);
      check("c0_busywait", 32'(c0_busywait),
            32'((c0_read | c0_write) && !(m_rel && m_port == 0)));
      check("c1_busywait", 32'(c1_busywait),
            32'((c1_read | c1_write) && !(m_rel && m_port == 1)));
    end
  end

  // Hold requests until each port is released, dropping each at the edge ending its RELEASE.
  task automatic serve(output int first_port, output int stall0);
    bit d0, d1;
    first_port = -1;
    stall0 = 0;
    for (int k = 0; k < 100; k++) begin
      if (!(c0_read | c0_write | c1_read | c1_write)) break;
      @(negedge clock);
      d0 = (c0_read | c0_write) && !c0_busywait;
      d1 = (c1_read | c1_write) && !c1_busywait;
      if ((c0_read | c0_write) && c0_busywait) stall0++;
      if (first_port < 0) begin
        if (d0) first_port = 0;
        else if (d1) first_port = 1;
      end
      @(posedge clock); #1;
      if (d0) begin c0_read = 0; c0_write = 0; end
      if (d1) begin c1_read = 0; c1_write = 0; end
    end
    check("serve_done", 32'(c0_read | c0_write | c1_read | c1_write), 32'd0);
    c0_read = 0; c0_write = 0; c1_read = 0; c1_write = 0;
  endtask

  int fp, st, exp_tie2;

  initial begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_tie2 = 0;
`else
    exp_tie2 = 1;
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_writedata", mem_writedata, 32'd0);
    check("rst_c0_readdata", c0_readdata, 32'd0);
    check("rst_c1_readdata", c1_readdata, 32'd0);
    check("rst_busy", 32'({c1_busywait, c0_busywait}), 32'd0);
    reset = 1'b1;
    chk_en = 1;
    @(posedge clock); #1;

    // Tie right after reset: port 0 first.
    mem_lat = 2;
    c0_read = 1; c0_address = 6'h01; c1_read = 1; c1_address = 6'h02;
    serve(fp, st);
    $display("tie1: first=%0d c0=%h c1=%h", fp, c0_readdata, c1_readdata);
    check("tie1_first", 32'(fp), 32'd0);
    check("tie1_c0_rd", c0_readdata, 32'hA5000001);
    check("tie1_c1_rd", c1_readdata, 32'hA5000002);

    // Single read, 5 busy cycles.
    mem_lat = 5;
    c0_read = 1; c0_address = 6'h05;
    serve(fp, st);
    $display("read0: stall=%0d c0=%h", st, c0_readdata);
    check("read_stall", 32'(st), 32'd7);
    check("read_c0_rd", c0_readdata, 32'hDEADBEEF);
    check("read_c1_rd", c1_readdata, 32'hA5000002);

    // Second tie after port 0 was last served.
    mem_lat = 2;
    c0_read = 1; c0_address = 6'h10; c1_read = 1; c1_address = 6'h11;
    serve(fp, st);
    $display("tie2: first=%0d c0=%h c1=%h", fp, c0_readdata, c1_readdata);
    check("tie2_first", 32'(fp), 32'(exp_tie2));
    check("tie2_c0_rd", c0_readdata, 32'hA5000010);
    check("tie2_c1_rd", c1_readdata, 32'hA5000011);

    // Single write on port 1.
    mem_lat = 3;
    c1_write = 1; c1_address = 6'h3F; c1_writedata = 32'h01020304;
    @(posedge clock); #1;
    @(negedge clock);
    check("wr_mem_write", 32'(mem_write), 32'd1);
    check("wr_mem_addr", 32'(mem_address), 32'h3F);
    check("wr_mem_wdata", mem_writedata, 32'h01020304);
    serve(fp, st);
    $display("write1: c1=%h", c1_readdata);
    check("wr_c1_rd", c1_readdata, 32'hA5000011);

    // Address change during ACCESS is ignored.
    mem_lat = 4;
    c0_read = 1; c0_address = 6'h05;
    @(posedge clock); #1;
    @(posedge clock); #1;
    c0_address = 6'h09;
    @(negedge clock);
    check("frz_mem_addr", 32'(mem_address), 32'h05);
    serve(fp, st);
    $display("freeze: c0=%h", c0_readdata);
    check("frz_c0_rd", c0_readdata, 32'hDEADBEEF);

    // Read and write together is a write.
    mem_lat = 1;
    c0_read = 1; c0_write = 1; c0_address = 6'h20; c0_writedata = 32'hCAFEF00D;
    @(posedge clock); #1;
    @(negedge clock);
    check("rw_mem_write", 32'(mem_write), 32'd1);
    check("rw_mem_read", 32'(mem_read), 32'd0);
    serve(fp, st);
    $display("rw: c0=%h", c0_readdata);
    check("rw_c0_rd", c0_readdata, 32'hDEADBEEF);

    // Reset during the third busy cycle.
    mem_lat = 6;
    c0_read = 1; c0_address = 6'h07;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("pre_rst_mem_read", 32'(mem_read), 32'd1);
    #1 reset = 1'b0;
    #1;
    $display("midrst: mem_read=%0d c0=%h", mem_read, c0_readdata);
    check("midrst_mem_read", 32'(mem_read), 32'd0);
    check("midrst_c0_rd", c0_readdata, 32'd0);
    c0_read = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("postrst_mem_read", 32'(mem_read), 32'd0);
    check("postrst_busy", 32'(c0_busywait), 32'd0);

    // Recovery read on port 1.
    @(posedge clock); #1;
    mem_lat = 1;
    c1_read = 1; c1_address = 6'h05;
    serve(fp, st);
    $display("recover: first=%0d c1=%h", fp, c1_readdata);
    check("rec_first", 32'(fp), 32'd1);
    check("rec_c1_rd", c1_readdata, 32'hDEADBEEF);

    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
